// File: rtl/stack_seq_pkg.sv
// Opcodes, response status codes and FSM states shared by the stack ALU sequencer.
package stack_seq_pkg;

    localparam logic [2:0] OP_IDLE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_DEPTH   = 2'b01;
    localparam logic [1:0] ST_ILLEGAL = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } seq_state_e;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_POP) || (op == OP_ADD) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Host-side command/response bus of the stack ALU sequencer.
interface stack_alu_sequencer_if #(
    parameter int unsigned N = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [N-1:0] cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_ovf;
    logic [1:0]   rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_status
    );
endinterface

// File: rtl/stack_depth_tracker.sv
// Shadow stack depth: saturating up/down counter with registered occupancy flags.
module stack_depth_tracker #(
    parameter int unsigned MAX_SIZE = 1024,
    localparam int unsigned DW      = $clog2(MAX_SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [DW-1:0] depth_o,
    output logic          can_push_o,
    output logic          can_pop1_o,
    output logic          can_pop2_o
);
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic          can_push_q;
    logic          can_pop1_q;
    logic          can_pop2_q;

    always_comb begin
        depth_d = depth_q;
        if (inc_i && !dec_i && (depth_q < DW'(MAX_SIZE))) begin
            depth_d = depth_q + DW'(1);
        end else if (dec_i && !inc_i && (depth_q != '0)) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // Flags track the next depth so they line up with depth_q every cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            depth_q    <= '0;
            can_push_q <= 1'b1;
            can_pop1_q <= 1'b0;
            can_pop2_q <= 1'b0;
        end else begin
            depth_q    <= depth_d;
            can_push_q <= depth_d < DW'(MAX_SIZE);
            can_pop1_q <= depth_d >= DW'(1);
            can_pop2_q <= depth_d >= DW'(2);
        end
    end

    assign depth_o    = depth_q;
    assign can_push_o = can_push_q;
    assign can_pop1_o = can_pop1_q;
    assign can_pop2_o = can_pop2_q;

endmodule

// File: rtl/stack_alu_sequencer.sv
// Command front-end for the ALU stack: range-checks commands against a shadow
// depth, issues them one at a time and returns one response per command.
module stack_alu_sequencer
    import stack_seq_pkg::*;
#(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_SIZE = 1024,
    parameter int unsigned TIMEOUT  = 15,
    localparam int unsigned DW      = $clog2(MAX_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    stack_alu_sequencer_if.slave host,
    output logic [2:0]           stk_opcode,
    output logic [N-1:0]         stk_data,
    input  logic [N-1:0]         stk_out,
    input  logic                 stk_overflow,
    input  logic                 stk_success,
    output logic [DW-1:0]        depth
);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_e   state_q;
    logic [2:0]   op_q;
    logic [N-1:0] data_q;
    logic [TW-1:0] cnt_q;
    logic         cmd_ready_q;
    logic [2:0]   stk_opcode_q;
    logic [N-1:0] stk_data_q;
    logic         rsp_valid_q;
    logic [N-1:0] rsp_data_q;
    logic         rsp_ovf_q;
    logic [1:0]   rsp_status_q;

    logic depth_ok;
    logic stk_done;
    logic depth_inc;
    logic depth_dec;
    logic can_push;
    logic can_pop1;
    logic can_pop2;

    stack_depth_tracker #(
        .MAX_SIZE (MAX_SIZE)
    ) u_depth (
        .clk        (clk),
        .rst        (rst),
        .inc_i      (depth_inc),
        .dec_i      (depth_dec),
        .depth_o    (depth),
        .can_push_o (can_push),
        .can_pop1_o (can_pop1),
        .can_pop2_o (can_pop2)
    );

    // Operand requirement of the latched command against the shadow depth.
    always_comb begin
        depth_ok = 1'b0;
        case (op_q)
            OP_PUSH:        depth_ok = can_push;
            OP_POP:         depth_ok = can_pop1;
            OP_ADD, OP_MUL: depth_ok = can_pop2;
            default:        depth_ok = 1'b0;
        endcase
    end

    assign stk_done  = (state_q == S_WAIT) && stk_success;
    assign depth_inc = stk_done && (op_q == OP_PUSH);
    assign depth_dec = stk_done && (op_q == OP_POP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_IDLE;
            data_q       <= '0;
            cnt_q        <= '0;
            cmd_ready_q  <= 1'b1;
            stk_opcode_q <= OP_IDLE;
            stk_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_ovf_q    <= 1'b0;
            rsp_status_q <= ST_OK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (host.cmd_valid && cmd_ready_q) begin
                        op_q        <= host.cmd_op;
                        data_q      <= host.cmd_data;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!op_is_legal(op_q) || !depth_ok) begin
                        rsp_status_q <= op_is_legal(op_q) ? ST_DEPTH : ST_ILLEGAL;
                        rsp_data_q   <= '0;
                        rsp_ovf_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        stk_opcode_q <= op_q;
                        stk_data_q   <= data_q;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    stk_opcode_q <= OP_IDLE;
                    stk_data_q   <= '0;
                    cnt_q        <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (stk_success) begin
                        rsp_status_q <= ST_OK;
                        rsp_data_q   <= (op_q == OP_PUSH) ? '0 : stk_out;
                        rsp_ovf_q    <= stk_overflow;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        rsp_status_q <= ST_TIMEOUT;
                        rsp_data_q   <= '0;
                        rsp_ovf_q    <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                S_RESP: begin
                    if (host.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign host.cmd_ready  = cmd_ready_q;
    assign host.rsp_valid  = rsp_valid_q;
    assign host.rsp_data   = rsp_data_q;
    assign host.rsp_ovf    = rsp_ovf_q;
    assign host.rsp_status = rsp_status_q;
    assign stk_opcode      = stk_opcode_q;
    assign stk_data        = stk_data_q;

endmodule

// File: tb/tb_stack_alu_sequencer.sv
// Bench for stack_alu_sequencer with a behavioural 4-bit ALU stack model and a
// response scoreboard.
module tb_stack_alu_sequencer;
    import stack_seq_pkg::*;

    localparam int unsigned N        = 4;
    localparam int unsigned MAX_SIZE = 4;
    localparam int unsigned TIMEOUT  = 15;
    localparam int unsigned DW       = $clog2(MAX_SIZE + 1);

    typedef struct packed {
        logic [N-1:0] data;
        logic         ovf;
        logic [1:0]   status;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    stk_opcode;
    logic [N-1:0]  stk_data;
    logic [N-1:0]  stk_out;
    logic          stk_overflow;
    logic          stk_success;
    logic [DW-1:0] depth;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    stack_alu_sequencer_if #(.N(N)) bus ();

    stack_alu_sequencer #(
        .N        (N),
        .MAX_SIZE (MAX_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (bus),
        .stk_opcode   (stk_opcode),
        .stk_data     (stk_data),
        .stk_out      (stk_out),
        .stk_overflow (stk_overflow),
        .stk_success  (stk_success),
        .depth        (depth)
    );

    always #5 clk = ~clk;

    // Behavioural ALU stack: add/mul leave both operands in place.
    logic [N-1:0] mem [0:7];
    logic [3:0]   sp;
    int           stk_lat    = 1;
    bit           stack_dead = 1'b0;
    int           dly;
    logic [N-1:0] res_c, res_q;
    logic         ovf_c, ovf_q;
    logic [2:0]   ti, ni;
    logic [N-1:0] a, b;
    logic [4:0]   s;
    logic [7:0]   p;

    always_comb begin
        ti    = sp[2:0] - 3'd1;
        ni    = sp[2:0] - 3'd2;
        a     = mem[ti];
        b     = mem[ni];
        s     = {a[3], a} + {b[3], b};
        p     = {{4{a[3]}}, a} * {{4{b[3]}}, b};
        res_c = '0;
        ovf_c = 1'b0;
        case (stk_opcode)
            OP_ADD: begin res_c = s[3:0]; ovf_c = (s[4] != s[3]); end
            OP_MUL: begin res_c = p[3:0]; ovf_c = (p[7:3] != 5'b00000) && (p[7:3] != 5'b11111); end
            OP_POP: res_c = a;
            default: res_c = '0;
        endcase
    end

    always @(posedge clk) begin
        if (!rst) begin
            sp           <= '0;
            dly          <= 0;
            stk_success  <= 1'b0;
            stk_out      <= '0;
            stk_overflow <= 1'b0;
            res_q        <= '0;
            ovf_q        <= 1'b0;
        end else begin
            stk_success <= 1'b0;
            if (stk_opcode != OP_IDLE && !stack_dead) begin
                if (stk_opcode == OP_PUSH) begin
                    mem[sp[2:0]] <= stk_data;
                    sp           <= sp + 4'd1;
                end else if (stk_opcode == OP_POP) begin
                    sp <= sp - 4'd1;
                end
                res_q <= res_c;
                ovf_q <= ovf_c;
                if (stk_lat <= 1) begin
                    stk_success  <= 1'b1;
                    stk_out      <= res_c;
                    stk_overflow <= ovf_c;
                    dly          <= 0;
                end else begin
                    dly <= stk_lat - 1;
                end
            end else if (dly == 1) begin
                stk_success  <= 1'b1;
                stk_out      <= res_q;
                stk_overflow <= ovf_q;
                dly          <= 0;
            end else if (dly > 1) begin
                dly <= dly - 1;
            end
        end
    end

    // Opcode activity monitor: total issue cycles and longest contiguous run.
    int opc_cycles = 0;
    int opc_run    = 0;
    int opc_max    = 0;
    always @(negedge clk) begin
        if (stk_opcode != OP_IDLE) begin
            opc_cycles <= opc_cycles + 1;
            opc_run    <= opc_run + 1;
            if (opc_run + 1 > opc_max) opc_max <= opc_run + 1;
        end else begin
            opc_run <= 0;
        end
    end

    function automatic exp_t mk(input logic [N-1:0] d, input logic o, input logic [1:0] st);
        exp_t e;
        e.data   = d;
        e.ovf    = o;
        e.status = st;
        return e;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [N-1:0] d, input bit want_rsp, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept op=%b: cmd_ready=%b, required 1 within 50 cycles", op, bus.cmd_ready);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        if (want_rsp) sb.push_back(e);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_IDLE;
        bus.cmd_data  = '0;
    endtask

    task automatic collect_rsp(input string tag);
        int   n;
        exp_t e, got;
        n = 0;
        while (!bus.rsp_valid && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: rsp_valid=%b, required 1 within 60 cycles", tag, bus.rsp_valid);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        got = mk(bus.rsp_data, bus.rsp_ovf, bus.rsp_status);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected response data=%h ovf=%b status=%b, required none", tag, got.data, got.ovf, got.status);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s: data=%h ovf=%b status=%b, required data=%h ovf=%b status=%b",
                         tag, got.data, got.ovf, got.status, e.data, e.ovf, e.status);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [N-1:0] d, input exp_t e, input string tag);
        send_cmd(op, d, 1'b1, e);
        collect_rsp(tag);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_IDLE;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", bus.cmd_ready); end
        checks++;
        if ({bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_status} !== '0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b data=%h ovf=%b status=%b, required all 0", bus.rsp_valid, bus.rsp_data, bus.rsp_ovf, bus.rsp_status);
        end
        checks++;
        if ({stk_opcode, stk_data} !== '0) begin errors++; $display("FAIL reset_stk: opcode=%b data=%h, required 0", stk_opcode, stk_data); end
        checks++;
        if (depth !== '0) begin errors++; $display("FAIL reset_depth: got %0d, required 0", depth); end
        rst = 1'b1;
    endtask

    task automatic test_add();
        do_cmd(OP_PUSH, 4'd3, mk(4'd0, 1'b0, ST_OK), "add_push3");
        do_cmd(OP_PUSH, 4'd2, mk(4'd0, 1'b0, ST_OK), "add_push2");
        do_cmd(OP_ADD,  4'd0, mk(4'd5, 1'b0, ST_OK), "add_3p2");
        checks++;
        if (depth !== DW'(2)) begin errors++; $display("FAIL add_depth: got %0d, required 2", depth); end
        checks++;
        if (opc_max !== 1) begin errors++; $display("FAIL issue_pulse: longest opcode run %0d cycles, required 1", opc_max); end
    endtask

    task automatic test_add_ovf_pop();
        apply_reset();
        do_cmd(OP_PUSH, 4'd7, mk(4'd0, 1'b0, ST_OK), "ovf_push7");
        do_cmd(OP_PUSH, 4'd1, mk(4'd0, 1'b0, ST_OK), "ovf_push1");
        do_cmd(OP_ADD,  4'd0, mk(4'h8, 1'b1, ST_OK), "ovf_add_7p1");
        do_cmd(OP_POP,  4'd0, mk(4'd1, 1'b0, ST_OK), "pop_first");
        do_cmd(OP_POP,  4'd0, mk(4'd7, 1'b0, ST_OK), "pop_second");
        checks++;
        if (depth !== DW'(0)) begin errors++; $display("FAIL pop_depth: got %0d, required 0", depth); end
    endtask

    task automatic test_mul();
        apply_reset();
        stk_lat = 3;
        do_cmd(OP_PUSH, 4'hD, mk(4'd0, 1'b0, ST_OK), "mul_push_m3");
        do_cmd(OP_PUSH, 4'd2, mk(4'd0, 1'b0, ST_OK), "mul_push2");
        do_cmd(OP_MUL,  4'd0, mk(4'hA, 1'b0, ST_OK), "mul_m3x2");
        do_cmd(OP_PUSH, 4'd4, mk(4'd0, 1'b0, ST_OK), "mul_push4a");
        do_cmd(OP_PUSH, 4'd4, mk(4'd0, 1'b0, ST_OK), "mul_push4b");
        do_cmd(OP_MUL,  4'd0, mk(4'd0, 1'b1, ST_OK), "mul_4x4_ovf");
        stk_lat = 1;
        checks++;
        if (depth !== DW'(4)) begin errors++; $display("FAIL mul_depth: got %0d, required 4", depth); end
    endtask

    task automatic test_depth_bounds();
        int snap;
        apply_reset();
        snap = opc_cycles;
        do_cmd(OP_POP, 4'd0, mk(4'd0, 1'b0, ST_DEPTH), "pop_empty");
        checks++;
        if (opc_cycles !== snap) begin errors++; $display("FAIL pop_empty_idle: opcode cycles %0d, required %0d", opc_cycles, snap); end
        checks++;
        if (depth !== DW'(0)) begin errors++; $display("FAIL pop_empty_depth: got %0d, required 0", depth); end
        snap = opc_cycles;
        for (int i = 1; i <= 5; i++) begin
            do_cmd(OP_PUSH, N'(i), mk(4'd0, 1'b0, (i == 5) ? ST_DEPTH : ST_OK), (i == 5) ? "push_full" : "push_fill");
        end
        checks++;
        if (opc_cycles !== snap + 4) begin errors++; $display("FAIL push_full_issues: opcode cycles %0d, required %0d", opc_cycles, snap + 4); end
        checks++;
        if (depth !== DW'(4)) begin errors++; $display("FAIL push_full_depth: got %0d, required 4", depth); end
    endtask

    task automatic test_illegal_backpressure();
        int n;
        apply_reset();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b011;
        bus.cmd_data  = 4'd0;
        sb.push_back(mk(4'd0, 1'b0, ST_ILLEGAL));
        @(negedge clk);
        bus.cmd_op   = OP_PUSH;
        bus.cmd_data = 4'd9;
        sb.push_back(mk(4'd0, 1'b0, ST_OK));
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge clk); n++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_status !== ST_ILLEGAL || bus.rsp_data !== 4'd0 ||
                bus.rsp_ovf !== 1'b0 || bus.cmd_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: valid=%b status=%b data=%h ovf=%b cmd_ready=%b, required 1/10/0/0/0",
                         c, bus.rsp_valid, bus.rsp_status, bus.rsp_data, bus.rsp_ovf, bus.cmd_ready);
            end
            @(negedge clk);
        end
        collect_rsp("illegal_op");
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: rsp_valid=%b cmd_ready=%b, required 0/1", bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = OP_IDLE;
        bus.cmd_data  = '0;
        collect_rsp("held_push");
        checks++;
        if (depth !== DW'(1)) begin errors++; $display("FAIL held_push_depth: got %0d, required 1", depth); end
    endtask

    task automatic test_reset_mid_and_timeout();
        int seen;
        apply_reset();
        stk_lat = 10;
        send_cmd(OP_PUSH, 4'd5, 1'b0, mk(4'd0, 1'b0, ST_OK));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (bus.cmd_ready !== 1'b1 || depth !== DW'(0) || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cmd_ready=%b depth=%0d rsp_valid=%b, required 1/0/0", bus.cmd_ready, depth, bus.rsp_valid);
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL mid_reset_norsp: rsp_valid high %0d cycles, required 0", seen); end
        stk_lat    = 1;
        stack_dead = 1'b1;
        send_cmd(OP_PUSH, 4'd6, 1'b1, mk(4'd0, 1'b0, ST_TIMEOUT));
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL timeout_early: rsp_valid high %0d cycles before timeout, required 0", seen); end
        collect_rsp("timeout");
        checks++;
        if (depth !== DW'(0)) begin errors++; $display("FAIL timeout_depth: got %0d, required 0", depth); end
        stack_dead = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_add_ovf_pop();
        test_mul();
        test_depth_bounds();
        test_illegal_backpressure();
        test_reset_mid_and_timeout();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
